// File: rtl/pipe_hazard_if.sv
// Decode-side hazard interface: decode operand/destination info in, stall/flush/forward selects out.
interface pipe_hazard_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned STAGES = 2
);
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic              dec_rs1_used;
    logic              dec_rs2_used;
    logic [ADDR_W-1:0] dec_rd;
    logic              dec_we;
    logic              dec_is_load;
    logic              br_taken;
    logic              stall;
    logic              flush;
    logic [STAGES-1:0] fwd_a_sel;
    logic [STAGES-1:0] fwd_b_sel;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_we, dec_is_load, br_taken,
        input  stall, flush, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_we, dec_is_load, br_taken,
        output stall, flush, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based forwarding, load-use stall and branch flush control for decode.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_unit #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned LOAD_STAGE  = 1,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_if.slave        hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]         stall_count
`endif
);
    localparam int unsigned FCNT_W = $clog2(FLUSH_DEPTH + 1);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0]             we_q, we_d;
    logic [STAGES-1:0]             ld_q, ld_d;
    logic [STAGES-1:0][ADDR_W-1:0] rd_q, rd_d;
    logic [FCNT_W-1:0]             fcnt_q, fcnt_d;

    logic [STAGES:0] src_a;
    logic [STAGES:0] src_b;
    logic            br_hon;
    logic            flush_c;
    logic            stall_c;

    // Youngest matching entry; MSB flags a load not yet forwardable, else one-hot select.
    function automatic logic [STAGES:0] find_src(
        input logic [ADDR_W-1:0]             s,
        input logic                          used,
        input logic [STAGES-1:0]             vld,
        input logic [STAGES-1:0]             we,
        input logic [STAGES-1:0]             ld,
        input logic [STAGES-1:0][ADDR_W-1:0] rd
    );
        logic [STAGES:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (!found && vld[k] && we[k] && (rd[k] == s) && (s != '0) && used) begin
                found = 1'b1;
                if (ld[k] && (k < LOAD_STAGE)) res[STAGES] = 1'b1;
                else                            res[k]      = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        src_a   = find_src(hz.dec_rs1, hz.dec_rs1_used, valid_q, we_q, ld_q, rd_q);
        src_b   = find_src(hz.dec_rs2, hz.dec_rs2_used, valid_q, we_q, ld_q, rd_q);
        br_hon  = hz.br_taken & valid_q[0] & (fcnt_q == '0);
        flush_c = br_hon | (fcnt_q != '0);
        stall_c = hz.dec_valid & (src_a[STAGES] | src_b[STAGES]) & ~flush_c;
    end

    assign hz.stall     = stall_c;
    assign hz.flush     = flush_c;
    assign hz.fwd_a_sel = src_a[STAGES-1:0];
    assign hz.fwd_b_sel = src_b[STAGES-1:0];

    // Scoreboard shift and flush window countdown.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        fcnt_d  = fcnt_q;
        for (int k = int'(STAGES) - 1; k > 0; k--) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        valid_d[0] = hz.dec_valid & ~stall_c & ~flush_c;
        we_d[0]    = hz.dec_we;
        ld_d[0]    = hz.dec_is_load;
        rd_d[0]    = hz.dec_rd;
        if (br_hon)                fcnt_d = FCNT_W'(FLUSH_DEPTH - 1);
        else if (fcnt_q != '0)     fcnt_d = fcnt_q - FCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            we_q    <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Saturating count of stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_count_q <= '0;
        else        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif
endmodule
